// File: rtl/neuron_dot_fp32.sv
// neuron_dot_fp32: sequential fp32 dot product with bias seed, one mul and one add per pair, sticky IEEE flags.
module neuron_dot_fp32 #(
  parameter int N_INPUTS = 4,
  localparam int CNT_W = $clog2(N_INPUTS + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bias,
  input  logic [2:0]  round_mode,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [31:0] in_w,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_z,
  output logic [4:0]  exceptions,
  output logic        busy
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_ADD, S_DONE} state_t;
  localparam logic [36:0] NAN_NV = {5'b10000, 32'h7fc00000};
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_acc, r_prod, r_x, r_w, r_out_z;
  logic [2:0]         r_rm;
  logic [4:0]         r_flags, r_exc;
  logic               r_out_valid;
  logic [36:0]        w_mul, w_add;
  // m: 24-bit significand (leading one at bit 25), round bit, sticky; returns {NV,DZ,OF,UF,NX, z}
  function automatic logic [36:0] rnd(input logic s, input logic signed [11:0] e_in,
                                      input logic [25:0] m, input logic [2:0] rm);
    logic inc, to_inf;
    logic [24:0] mr;
    logic signed [11:0] e;
    inc = rm == 3'b000 ? m[1] & (m[0] | m[2]) :
          rm == 3'b010 ? s & (m[1] | m[0]) :
          rm == 3'b011 ? ~s & (m[1] | m[0]) :
          rm == 3'b100 ? m[1] : 1'b0;
    mr = {1'b0, m[25:2]} + {24'd0, inc};
    e = mr[24] ? e_in + 12'sd1 : e_in;
    mr = mr[24] ? mr >> 1 : mr;
    to_inf = rm == 3'b000 || rm == 3'b100 || (rm == 3'b011 && !s) || (rm == 3'b010 && s);
    if (e <= 0) return {5'b00011, s, 31'd0};
    if (e >= 255) return {5'b00101, to_inf ? {s, 8'hff, 23'd0} : {s, 8'hfe, 23'h7fffff}};
    return {4'b0000, m[1] | m[0], s, e[7:0], mr[22:0]};
  endfunction
  function automatic logic [36:0] fmul(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
    logic s, az, bz, ai, bi, an, bn;
    logic [47:0] p;
    logic signed [11:0] e;
    s  = a[31] ^ b[31];
    az = a[30:23] == 8'd0;
    bz = b[30:23] == 8'd0;
    ai = a[30:23] == 8'hff && a[22:0] == 23'd0;
    bi = b[30:23] == 8'hff && b[22:0] == 23'd0;
    an = a[30:23] == 8'hff && a[22:0] != 23'd0;
    bn = b[30:23] == 8'hff && b[22:0] != 23'd0;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = 12'(a[30:23]) + 12'(b[30:23]) + 12'(p[47]) - 12'd127;
    if (an || bn || (ai && bz) || (bi && az)) return NAN_NV;
    if (ai || bi) return {5'd0, s, 8'hff, 23'd0};
    if (az || bz) return {5'd0, s, 31'd0};
    return rnd(s, e, p[47] ? {p[47:24], p[23], |p[22:0]} : {p[46:23], p[22], |p[21:0]}, rm);
  endfunction
  function automatic logic [36:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
    logic az, bz, ai, bi, an, bn, sub;
    logic [31:0] x, y;
    logic [7:0]  d;
    logic [50:0] mx, my, sm, nrm;
    logic signed [11:0] e;
    int p;
    az  = a[30:23] == 8'd0;
    bz  = b[30:23] == 8'd0;
    ai  = a[30:23] == 8'hff && a[22:0] == 23'd0;
    bi  = b[30:23] == 8'hff && b[22:0] == 23'd0;
    an  = a[30:23] == 8'hff && a[22:0] != 23'd0;
    bn  = b[30:23] == 8'hff && b[22:0] != 23'd0;
    sub = a[31] ^ b[31];
    if (an || bn || (ai && bi && sub)) return NAN_NV;
    if (ai) return {5'd0, a};
    if (bi) return {5'd0, b};
    if (az && bz) return {5'd0, (a[31] & b[31]) | (sub & (rm == 3'b010)), 31'd0};
    if (az) return {5'd0, b};
    if (bz) return {5'd0, a};
    {x, y} = a[30:0] >= b[30:0] ? {a, b} : {b, a};
    d  = x[30:23] - y[30:23];
    mx = {2'b01, x[22:0], 26'd0};
    // 26 guard bits keep alignment exact up to d=26; beyond that only stickiness matters
    my = d > 8'd26 ? 51'd1 : {2'b01, y[22:0], 26'd0} >> d;
    sm = sub ? mx - my : mx + my;
    if (sm == 51'd0) return {5'd0, rm == 3'b010, 31'd0};
    p = 0;
    for (int i = 0; i < 51; i++) p = sm[i] ? i : p;
    nrm = sm << (50 - p);
    e = 12'(x[30:23]) + 12'(p - 49);
    return rnd(x[31], e, {nrm[50:27], nrm[26], |nrm[25:0]}, rm);
  endfunction
  assign w_mul      = fmul(r_x, r_w, r_rm);
  assign w_add      = fadd(r_acc, r_prod, r_rm);
  assign in_ready   = r_state == S_LOAD;
  assign busy       = r_state != S_IDLE;
  assign out_valid  = r_out_valid;
  assign out_z      = r_out_z;
  assign exceptions = r_exc;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_prod      <= '0;
      r_x         <= '0;
      r_w         <= '0;
      r_rm        <= '0;
      r_flags     <= '0;
      r_exc       <= '0;
      r_out_z     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_LOAD;
          r_acc   <= bias;
          r_rm    <= round_mode;
          r_flags <= '0;
          r_cnt   <= '0;
        end
        S_LOAD: if (in_valid) begin
          r_x     <= in_x;
          r_w     <= in_w;
          r_state <= S_MUL;
        end
        S_MUL: begin
          r_prod  <= w_mul[31:0];
          r_flags <= r_flags | w_mul[36:32];
          r_state <= S_ADD;
        end
        S_ADD: begin
          r_acc   <= w_add[31:0];
          r_flags <= r_flags | w_add[36:32];
          r_cnt   <= r_cnt + CNT_W'(1);
          r_state <= r_cnt == CNT_W'(N_INPUTS - 1) ? S_DONE : S_LOAD;
        end
        S_DONE: if (!r_out_valid) begin
          r_out_valid <= 1'b1;
          r_out_z     <= r_acc;
          r_exc       <= r_flags;
        end else if (out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
